// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position commit controller.
package sprite_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } state_e;

   localparam int OBJ_PLAYER  = 0;
   localparam int OBJ_ENEMY   = 1;
   localparam int OBJ_BULLET  = 2;
   localparam int OBJ_EBULLET = 3;
   localparam int OBJ_BULLET2 = 4;

   localparam int DEF_NUM_OBJ = 5;
   localparam int DEF_X_W     = 10;
   localparam int DEF_Y_W     = 9;

endpackage

// File: rtl/sprite_commit_ctrl_if.sv
// Per-object position write handshake between game logic and the commit controller.
interface sprite_commit_ctrl_if #(
   parameter int NUM_OBJ = sprite_pkg::DEF_NUM_OBJ,
   parameter int X_W     = sprite_pkg::DEF_X_W,
   parameter int Y_W     = sprite_pkg::DEF_Y_W
);
   logic [NUM_OBJ-1:0]     req;
   logic [NUM_OBJ*X_W-1:0] wr_x;
   logic [NUM_OBJ*Y_W-1:0] wr_y;
   logic [NUM_OBJ-1:0]     ack;

   modport master (output req, output wr_x, output wr_y, input ack);
   modport slave  (input req, input wr_x, input wr_y, output ack);
endinterface

// File: rtl/sprite_commit_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after the pointer.
module rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] pointer,
   input  logic             enable,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);
   logic [N-1:0]     elig;
   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      elig      = req & ~mask;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IDX_W'((32'(pointer) + 32'(k)) % 32'(N));
         if (enable && !found && elig[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = idx;
         end
      end
   end
endmodule

// File: rtl/sprite_commit_ctrl.sv
// Arbitrates position writes into a shadow bank and copies dirty entries to the
// renderer-visible active bank in a sweep started by vertical blank.
//
// state  | meaning
// IDLE   | arbitration enabled, waiting for vblank_start
// COMMIT | sweeping c = 0..NUM_OBJ-1, copying dirty shadow entries to active
module sprite_commit_ctrl
   import sprite_pkg::*;
#(
   parameter int NUM_OBJ = DEF_NUM_OBJ,
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int OVR_W   = 8
) (
   input  logic                   master_clk,
   input  logic                   reset,
   sprite_commit_ctrl_if.slave    bus,
   input  logic                   vblank_start,
   output logic [NUM_OBJ*X_W-1:0] obj_x,
   output logic [NUM_OBJ*Y_W-1:0] obj_y,
   output logic [NUM_OBJ-1:0]     dirty,
   output logic                   commit_busy,
   output logic                   frame_done,
   output logic [OVR_W-1:0]       overrun_cnt
);
   localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     c_q, c_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [NUM_OBJ-1:0]   ack_q, ack_d;
   logic [NUM_OBJ-1:0]   dirty_q, dirty_d;
   logic                 frame_done_q, frame_done_d;
   logic [OVR_W-1:0]     ovr_q, ovr_d;
   logic [X_W-1:0]       sh_x_q [NUM_OBJ];
   logic [X_W-1:0]       sh_x_d [NUM_OBJ];
   logic [Y_W-1:0]       sh_y_q [NUM_OBJ];
   logic [Y_W-1:0]       sh_y_d [NUM_OBJ];
   logic [X_W-1:0]       act_x_q [NUM_OBJ];
   logic [X_W-1:0]       act_x_d [NUM_OBJ];
   logic [Y_W-1:0]       act_y_q [NUM_OBJ];
   logic [Y_W-1:0]       act_y_d [NUM_OBJ];
   logic [NUM_OBJ-1:0]   gnt;
   logic [IDX_W-1:0]     gnt_idx;

   // The requester currently seeing its ack is masked so a held req is not re-granted early.
   rr_arbiter #(.N(NUM_OBJ), .IDX_W(IDX_W)) u_arb (
      .req       (bus.req),
      .mask      (ack_q),
      .pointer   (ptr_q),
      .enable    (state_q == IDLE),
      .grant     (gnt),
      .grant_idx (gnt_idx)
   );

   always_comb begin
      state_d      = state_q;
      c_d          = c_q;
      ptr_d        = ptr_q;
      ack_d        = gnt;
      dirty_d      = dirty_q;
      frame_done_d = 1'b0;
      ovr_d        = ovr_q;
      sh_x_d       = sh_x_q;
      sh_y_d       = sh_y_q;
      act_x_d      = act_x_q;
      act_y_d      = act_y_q;

      for (int i = 0; i < NUM_OBJ; i++) begin
         if (gnt[i]) begin
            sh_x_d[i]  = bus.wr_x[i*X_W +: X_W];
            sh_y_d[i]  = bus.wr_y[i*Y_W +: Y_W];
            dirty_d[i] = 1'b1;
         end
      end
      if (|gnt) begin
         ptr_d = (gnt_idx == IDX_W'(NUM_OBJ-1)) ? '0 : gnt_idx + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (vblank_start) begin
               state_d = COMMIT;
               c_d     = '0;
            end
         end
         COMMIT: begin
            if (vblank_start && (ovr_q != '1)) begin
               ovr_d = ovr_q + 1'b1;
            end
            for (int i = 0; i < NUM_OBJ; i++) begin
               if ((IDX_W'(i) == c_q) && dirty_q[i]) begin
                  act_x_d[i] = sh_x_q[i];
                  act_y_d[i] = sh_y_q[i];
                  dirty_d[i] = 1'b0;
               end
            end
            if (c_q == IDX_W'(NUM_OBJ-1)) begin
               state_d      = IDLE;
               c_d          = '0;
               frame_done_d = 1'b1;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         c_q          <= '0;
         ptr_q        <= '0;
         ack_q        <= '0;
         dirty_q      <= '0;
         frame_done_q <= 1'b0;
         ovr_q        <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            sh_x_q[i]  <= '0;
            sh_y_q[i]  <= '0;
            act_x_q[i] <= '0;
            act_y_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         c_q          <= c_d;
         ptr_q        <= ptr_d;
         ack_q        <= ack_d;
         dirty_q      <= dirty_d;
         frame_done_q <= frame_done_d;
         ovr_q        <= ovr_d;
         sh_x_q       <= sh_x_d;
         sh_y_q       <= sh_y_d;
         act_x_q      <= act_x_d;
         act_y_q      <= act_y_d;
      end
   end

   always_comb begin
      obj_x = '0;
      obj_y = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         obj_x[i*X_W +: X_W] = act_x_q[i];
         obj_y[i*Y_W +: Y_W] = act_y_q[i];
      end
   end

   assign bus.ack     = ack_q;
   assign dirty       = dirty_q;
   assign commit_busy = (state_q == COMMIT);
   assign frame_done  = frame_done_q;
   assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Directed and random stimulus for sprite_commit_ctrl against a behavioural reference model.
module tb_sprite_commit_ctrl;
   localparam int NUM_OBJ = 5;
   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int OVR_W   = 8;

   logic                   master_clk = 1'b0;
   logic                   reset;
   logic                   vblank_start;
   logic [NUM_OBJ*X_W-1:0] obj_x;
   logic [NUM_OBJ*Y_W-1:0] obj_y;
   logic [NUM_OBJ-1:0]     dirty;
   logic                   commit_busy;
   logic                   frame_done;
   logic [OVR_W-1:0]       overrun_cnt;

   int errors = 0;
   int checks = 0;

   sprite_commit_ctrl_if #(.NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W)) bus ();

   sprite_commit_ctrl #(.NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W), .OVR_W(OVR_W)) dut (
      .master_clk   (master_clk),
      .reset        (reset),
      .bus          (bus),
      .vblank_start (vblank_start),
      .obj_x        (obj_x),
      .obj_y        (obj_y),
      .dirty        (dirty),
      .commit_busy  (commit_busy),
      .frame_done   (frame_done),
      .overrun_cnt  (overrun_cnt)
   );

   always #10 master_clk = ~master_clk;

   // Reference model: banks as plain arrays, sweep position as an integer (-1 = not committing).
   logic [X_W-1:0]     m_sx [NUM_OBJ];
   logic [Y_W-1:0]     m_sy [NUM_OBJ];
   logic [X_W-1:0]     m_ax [NUM_OBJ];
   logic [Y_W-1:0]     m_ay [NUM_OBJ];
   logic [NUM_OBJ-1:0] m_dirty;
   logic [NUM_OBJ-1:0] m_ack;
   logic               m_fd;
   int                 m_ptr;
   int                 m_sweep;
   int                 m_ovr;

   task automatic model_reset();
      for (int i = 0; i < NUM_OBJ; i++) begin
         m_sx[i] = '0; m_sy[i] = '0; m_ax[i] = '0; m_ay[i] = '0;
      end
      m_dirty = '0; m_ack = '0; m_fd = 1'b0;
      m_ptr = 0; m_sweep = -1; m_ovr = 0;
   endtask

   task automatic model_step();
      logic [NUM_OBJ-1:0] nack;
      logic nfd;
      int win;
      nack = '0;
      nfd  = 1'b0;
      win  = -1;
      if (m_sweep < 0) begin
         for (int k = 0; k < NUM_OBJ; k++) begin
            if (win < 0 && bus.req[(m_ptr + k) % NUM_OBJ] && !m_ack[(m_ptr + k) % NUM_OBJ])
               win = (m_ptr + k) % NUM_OBJ;
         end
         if (win >= 0) begin
            m_sx[win]    = bus.wr_x[win*X_W +: X_W];
            m_sy[win]    = bus.wr_y[win*Y_W +: Y_W];
            m_dirty[win] = 1'b1;
            nack[win]    = 1'b1;
            m_ptr        = (win + 1) % NUM_OBJ;
         end
         if (vblank_start) m_sweep = 0;
      end else begin
         if (vblank_start && m_ovr < 255) m_ovr = m_ovr + 1;
         if (m_dirty[m_sweep]) begin
            m_ax[m_sweep]    = m_sx[m_sweep];
            m_ay[m_sweep]    = m_sy[m_sweep];
            m_dirty[m_sweep] = 1'b0;
         end
         if (m_sweep == NUM_OBJ - 1) begin
            m_sweep = -1;
            nfd     = 1'b1;
         end else begin
            m_sweep = m_sweep + 1;
         end
      end
      m_ack = nack;
      m_fd  = nfd;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [X_W-1:0] gx(input int i);
      return obj_x[i*X_W +: X_W];
   endfunction

   function automatic logic [Y_W-1:0] gy(input int i);
      return obj_y[i*Y_W +: Y_W];
   endfunction

   task automatic check_all();
      chk("ack", bus.ack, m_ack);
      chk("dirty", dirty, m_dirty);
      chk("commit_busy", commit_busy, (m_sweep >= 0));
      chk("frame_done", frame_done, m_fd);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      for (int i = 0; i < NUM_OBJ; i++) begin
         chk("obj_x", gx(i), m_ax[i]);
         chk("obj_y", gy(i), m_ay[i]);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge master_clk);
      @(negedge master_clk);
      check_all();
   endtask

   task automatic set_req(input int i, input int x, input int y);
      bus.req[i] = 1'b1;
      bus.wr_x[i*X_W +: X_W] = X_W'(x);
      bus.wr_y[i*Y_W +: Y_W] = Y_W'(y);
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && commit_busy; n++) cyc();
      chk("drain_idle", commit_busy, 1'b0);
   endtask

   initial begin
      int order [$];
      int busy_n;
      int fd_n;
      logic [X_W-1:0] prev_x;

      reset = 1'b1;
      vblank_start = 1'b0;
      bus.req  = '0;
      bus.wr_x = '0;
      bus.wr_y = '0;
      model_reset();
      @(negedge master_clk);
      @(negedge master_clk);
      reset = 1'b0;
      check_all();

      // Contention with pointer 0: requesters drop req on their ack.
      bus.req = 5'b10101;
      for (int i = 0; i < NUM_OBJ; i++) set_req(i, $urandom_range(0, 1023), $urandom_range(0, 511));
      bus.req = 5'b10101;
      for (int n = 0; n < 10 && bus.req != 0; n++) begin
         cyc();
         for (int i = 0; i < NUM_OBJ; i++) if (bus.ack[i]) begin order.push_back(i); bus.req[i] = 1'b0; end
      end
      chk("rr1_count", order.size(), 3);
      if (order.size() == 3) begin
         chk("rr1_first", order[0], 0);
         chk("rr1_second", order[1], 2);
         chk("rr1_third", order[2], 4);
      end
      order.delete();
      bus.req = 5'b11111;
      for (int n = 0; n < 12 && bus.req != 0; n++) begin
         cyc();
         for (int i = 0; i < NUM_OBJ; i++) if (bus.ack[i]) begin order.push_back(i); bus.req[i] = 1'b0; end
      end
      chk("rr2_count", order.size(), 5);
      for (int i = 0; i < order.size() && i < NUM_OBJ; i++) chk("rr2_order", order[i], i);
      vblank_start = 1'b1;
      cyc();
      vblank_start = 1'b0;
      drain();

      // Single write then commit.
      prev_x = m_ax[0];
      set_req(0, 320, 240);
      cyc();
      bus.req[0] = 1'b0;
      chk("single_ack", bus.ack, 5'b00001);
      chk("single_dirty", dirty, 5'b00001);
      chk("single_obj_x_held", gx(0), prev_x);
      vblank_start = 1'b1;
      cyc();
      vblank_start = 1'b0;
      busy_n = commit_busy ? 1 : 0;
      fd_n = 0;
      for (int n = 0; n < 6; n++) begin
         cyc();
         busy_n += commit_busy ? 1 : 0;
         fd_n += frame_done ? 1 : 0;
      end
      chk("single_busy_len", busy_n, 5);
      chk("single_fd_count", fd_n, 1);
      chk("single_obj_x", gx(0), 320);
      chk("single_obj_y", gy(0), 240);
      chk("single_dirty_clr", dirty, 5'b00000);

      // Write during commit.
      prev_x = m_ax[1];
      vblank_start = 1'b1;
      cyc();
      vblank_start = 1'b0;
      cyc();
      set_req(1, 100, 77);
      for (int n = 0; n < 10 && !bus.ack[1]; n++) begin
         cyc();
         if (commit_busy) chk("wdc_no_ack_busy", bus.ack, 5'b00000);
      end
      chk("wdc_ack", bus.ack[1], 1'b1);
      bus.req[1] = 1'b0;
      chk("wdc_dirty", dirty[1], 1'b1);
      chk("wdc_obj_x_held", gx(1), prev_x);
      vblank_start = 1'b1;
      cyc();
      vblank_start = 1'b0;
      drain();
      chk("wdc_obj_x", gx(1), 100);

      // Overrun: two consecutive vblank pulses give one sweep.
      vblank_start = 1'b1;
      cyc();
      cyc();
      vblank_start = 1'b0;
      fd_n = 0;
      for (int n = 0; n < 8; n++) begin
         cyc();
         fd_n += frame_done ? 1 : 0;
      end
      chk("ovr_one_sweep", fd_n, 1);
      chk("ovr_one", overrun_cnt, 1);
      vblank_start = 1'b1;
      for (int n = 0; n < 400; n++) cyc();
      vblank_start = 1'b0;
      chk("ovr_saturate", overrun_cnt, 255);
      drain();

      // Request rising on the same edge as vblank_start.
      set_req(3, 50, 60);
      vblank_start = 1'b1;
      cyc();
      vblank_start = 1'b0;
      bus.req[3] = 1'b0;
      chk("same_edge_ack", bus.ack[3], 1'b1);
      chk("same_edge_busy", commit_busy, 1'b1);
      for (int n = 0; n < 5; n++) cyc();
      chk("same_edge_obj_x", gx(3), 50);
      chk("same_edge_obj_y", gy(3), 60);

      // Reset in the middle of a commit.
      set_req(2, 9, 9);
      cyc();
      bus.req[2] = 1'b0;
      vblank_start = 1'b1;
      cyc();
      vblank_start = 1'b0;
      cyc();
      reset = 1'b1;
      #2;
      model_reset();
      chk("rst_busy", commit_busy, 1'b0);
      chk("rst_ovr", overrun_cnt, 0);
      chk("rst_obj_x", obj_x, 0);
      chk("rst_obj_y", obj_y, 0);
      chk("rst_dirty", dirty, 0);
      chk("rst_ack", bus.ack, 0);
      @(negedge master_clk);
      reset = 1'b0;
      check_all();
      cyc();

      // Random requesters and vblank pulses.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (bus.req[i]) begin
               if (bus.ack[i]) begin
                  if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
                  else set_req(i, $urandom_range(0, 1023), $urandom_range(0, 511));
               end
            end else if ($urandom_range(0, 3) == 0) begin
               set_req(i, $urandom_range(0, 1023), $urandom_range(0, 511));
            end
         end
         vblank_start = ($urandom_range(0, 15) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
